// File: rtl/led_timer_pkg.sv
// Shared types and default sizing for the LED timer bank.
package led_timer_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam int DEF_NUM_CH    = 5;
    localparam int DEF_PRESC_DIV = 12_000_000 / 8;
    localparam int DEF_DUTY_W    = 8;

    // Channel index width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_timer_bank_if.sv
// Configuration write bus for the LED timer bank.
interface led_timer_bank_if #(
    parameter int NUM_CH = led_timer_pkg::DEF_NUM_CH,
    parameter int DUTY_W = led_timer_pkg::DEF_DUTY_W
);
    localparam int CH_W = led_timer_pkg::ch_idx_w(NUM_CH);

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [1:0]        wr_mode;
    logic [DUTY_W-1:0] wr_val;

    modport master (output wr_en, wr_ch, wr_mode, wr_val);
    modport slave  (input  wr_en, wr_ch, wr_mode, wr_val);

endinterface

// File: rtl/led_timer_ch.sv
// One LED channel: config registers, blink divider and next-LED mux.
module led_timer_ch
    import led_timer_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_sel_i,
    input  logic [1:0]        wr_mode_i,
    input  logic [DUTY_W-1:0] wr_val_i,
    input  logic              wrap_i,
    input  logic [DUTY_W-1:0] pwm_cnt_i,
    output logic              led_d_o
);

    mode_e             mode_q, mode_d;
    logic [DUTY_W-1:0] val_q, val_d;
    logic [DUTY_W-1:0] div_q, div_d;
    logic              blink_q, blink_d;

    // A write on the wrap cycle takes priority, so the divider restarts cleanly.
    always_comb begin
        mode_d  = mode_q;
        val_d   = val_q;
        div_d   = div_q;
        blink_d = blink_q;
        if (wr_sel_i) begin
            mode_d  = mode_e'(wr_mode_i);
            val_d   = wr_val_i;
            div_d   = '0;
            blink_d = 1'b0;
        end else if (mode_q != MODE_BLINK) begin
            div_d   = '0;
            blink_d = 1'b0;
        end else if (wrap_i) begin
            if (div_q == val_q) begin
                blink_d = ~blink_q;
                div_d   = '0;
            end else begin
                div_d = div_q + DUTY_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= MODE_OFF;
            val_q   <= '0;
            div_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            val_q   <= val_d;
            div_q   <= div_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        led_d_o = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d_o = 1'b0;
            MODE_ON:    led_d_o = 1'b1;
            MODE_BLINK: led_d_o = blink_q;
            MODE_PWM:   led_d_o = (pwm_cnt_i < val_q);
            default:    led_d_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_timer_bank.sv
// Bank of NUM_CH LED timers sharing one blink prescaler and one PWM phase counter.
module led_timer_bank
    import led_timer_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PRESC_DIV = DEF_PRESC_DIV,
    parameter int DUTY_W    = DEF_DUTY_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    led_timer_bank_if.slave   wr,
    output logic [NUM_CH-1:0] led,
    output logic              tick
);

    localparam int            CH_W      = ch_idx_w(NUM_CH);
    localparam int            PW        = $clog2(PRESC_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic              tick_q;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] wr_sel;
    logic              wrap;

    assign wrap      = (presc_q == PRESC_MAX);
    assign presc_d   = wrap ? '0 : presc_q + PW'(1);
    assign pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
            led_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= wrap;
            led_q     <= led_d;
        end
    end

    // Out-of-range channel indices match no lane and are dropped.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign wr_sel[k] = wr.wr_en && (wr.wr_ch == CH_W'(k));

        led_timer_ch #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .wr_sel_i  (wr_sel[k]),
            .wr_mode_i (wr.wr_mode),
            .wr_val_i  (wr.wr_val),
            .wrap_i    (wrap),
            .pwm_cnt_i (pwm_cnt_q),
            .led_d_o   (led_d[k])
        );
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule
